// File: rtl/stage_memory_pkg.sv
// Shared pipeline types for the memory stage: stage record, opcodes, bubble and fault constants.
// Combinational helpers only; no latency and no backpressure.
package stage_memory_pkg;

    typedef logic [31:0] V32;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        LD  = 4'd3,
        ST  = 4'd4
    } t_op;

    typedef struct packed {
        logic       valid;
        t_op        operation;
        logic [4:0] rd;
        V32         v1;
        V32         v2;
        V32         result;
    } t_stage;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } t_mem_state;

    // Load result substituted when the cache never answers.
    localparam V32 TIMEOUT_RDATA = 32'hDEADBEEF;

    localparam t_stage STAGE_BUBBLE = '{
        valid:     1'b0,
        operation: NOP,
        rd:        5'd0,
        v1:        32'd0,
        v2:        32'd0,
        result:    32'd0
    };

    function automatic t_stage stage_flush();
        return STAGE_BUBBLE;
    endfunction

    function automatic logic is_mem_op(input t_op op);
        return (op == LD) || (op == ST);
    endfunction

endpackage

// File: rtl/stage_memory_mem_handshake.sv
// Data-cache request FSM (IDLE/ACCESS/DONE): one request cycle minimum, waits for mem_ack;
// stall_in parks a finished access in DONE. Optional abort counter under MEM_TIMEOUT_EN.
import stage_memory_pkg::*;

module mem_handshake #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_stall_in,
    input  logic i_mem_op,
    input  logic i_is_store,
    input  V32   i_addr,
    input  V32   i_wdata,
    input  V32   i_mem_rdata,
    input  logic i_mem_ack,
    output logic o_complete,
    output V32   o_load_dat,
    output logic o_mem_req,
    output logic o_mem_we,
    output V32   o_mem_addr,
    output V32   o_mem_wdata,
    output logic o_mem_error
);

    t_mem_state r_state;
    t_mem_state w_next_state;
    logic       r_req;
    logic       r_we;
    V32         r_addr;
    V32         r_wdata;
    V32         r_rdata;
    logic       w_timeout;
    logic       w_finish;
    V32         w_access_dat;

    assign w_finish     = (r_state == ACCESS) && (i_mem_ack || w_timeout);
    assign w_access_dat = w_timeout ? TIMEOUT_RDATA : i_mem_rdata;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_mem_op)    w_next_state = ACCESS;
            ACCESS:  if (w_finish)    w_next_state = i_stall_in ? DONE : IDLE;
            DONE:    if (!i_stall_in) w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && i_mem_op) begin
                r_req   <= 1'b1;
                r_we    <= i_is_store;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end else if (w_finish) begin
                r_req   <= 1'b0;
                r_rdata <= w_access_dat;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_error;

    // Fires on the TIMEOUT_CYCLES-th unacknowledged ACCESS cycle; a real ack always wins.
    assign w_timeout = (r_state == ACCESS) && !i_mem_ack && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_error <= 1'b0;
        end else begin
            if (r_state == ACCESS && !i_mem_ack && !w_timeout) r_cnt <= r_cnt + 1'b1;
            else                                               r_cnt <= '0;
            if (w_timeout) r_error <= 1'b1;
        end
    end

    assign o_mem_error = r_error;
`else
    assign w_timeout   = 1'b0;
    assign o_mem_error = 1'b0;
`endif

    a_timeout_cfg: assert property (@(posedge i_clock) TIMEOUT_CYCLES >= 1);

    assign o_complete  = w_finish || (r_state == DONE);
    assign o_load_dat  = (r_state == ACCESS) ? w_access_dat : r_rdata;
    assign o_mem_req   = r_req;
    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage: non-memory ops pass in 1 cycle; LD/ST emit bubbles until the cache acks.
// stall_in freezes stage_out; stall_out is combinational. Abort counter under MEM_TIMEOUT_EN.
import stage_memory_pkg::*;

module stage_memory #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   stall_in,
    input  t_stage stage_in,
    output t_stage stage_out,
    output logic   stall_out,
    output logic   mem_req,
    output logic   mem_we,
    output V32     mem_addr,
    output V32     mem_wdata,
    input  V32     mem_rdata,
    input  logic   mem_ack,
    output logic   mem_error
);

    logic   w_mem_op;
    logic   w_complete;
    V32     w_load_dat;
    t_stage w_stage_next;
    t_stage r_stage;

    assign w_mem_op = is_mem_op(stage_in.operation);

    mem_handshake #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_mem_handshake (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_stall_in  (stall_in),
        .i_mem_op    (w_mem_op),
        .i_is_store  (stage_in.operation == ST),
        .i_addr      (stage_in.v1),
        .i_wdata     (stage_in.v2),
        .i_mem_rdata (mem_rdata),
        .i_mem_ack   (mem_ack),
        .o_complete  (w_complete),
        .o_load_dat  (w_load_dat),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_error (mem_error)
    );

    always_comb begin
        w_stage_next = stage_in;
        if (stage_in.operation == LD) w_stage_next.result = w_load_dat;
    end

    // A pending memory op emits bubbles so the instruction leaves the stage exactly once.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stage <= stage_flush();
        end else if (!stall_in) begin
            if (w_mem_op && !w_complete) r_stage <= stage_flush();
            else                         r_stage <= w_stage_next;
        end
    end

    assign stage_out = r_stage;
    assign stall_out = stall_in || (w_mem_op && !w_complete);

endmodule
